// File: rtl/sad_sched.sv
// Round-robin scheduler sharing one SAD engine among N_REQ requesters.
// Handles the engine enable/busy handshake, result capture and watchdog abort.
module sad_sched #(
  parameter int N_REQ   = 4,
  parameter int OFS_W   = 8,
  parameter int SAD_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*OFS_W-1:0] ofs_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   err_o,
  output logic [SAD_W-1:0]       sad_o,
  output logic                   busy_o,
  output logic                   sad_enb_o,
  output logic [OFS_W-1:0]       sad_ofs_o,
  input  logic                   sad_busy_i,
  input  logic [SAD_W-1:0]       sad_i
);

  localparam int          IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          TW = $clog2(TIMEOUT + 1);
  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {IDLE, START, RUN, SETTLE} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic               err_q, err_d, busy_q, busy_d, enb_q, enb_d;
  logic [SAD_W-1:0]   sad_q, sad_d;
  logic [OFS_W-1:0]   ofs_q, ofs_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [IW-1:0]      last_q, last_d, cur_q, cur_d;

  logic [N_REQ-1:0]   elig;
  logic               win_vld;
  logic [IW-1:0]      win_idx, scan_idx;
  logic [OFS_W-1:0]   ofs_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_ofs
    assign ofs_arr[g] = ofs_i[g*OFS_W +: OFS_W];
  end

  // A requester's own done cycle must not re-arm it, so done_q masks req_i.
  always_comb begin
    elig     = req_i & ~done_q;
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      scan_idx = IW'((32'(last_q) + i + 32'd1) % NR);
      if (!win_vld && elig[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    enb_d   = enb_q;
    sad_d   = sad_q;
    ofs_d   = ofs_q;
    timer_d = timer_q;
    last_d  = last_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: begin
        if (win_vld && !sad_busy_i) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          ofs_d          = ofs_arr[win_idx];
          enb_d          = 1'b1;
          busy_d         = 1'b1;
          timer_d        = '0;
          cur_d          = win_idx;
          state_d        = START;
        end
      end
      START, RUN: begin
        timer_d = timer_q + 1'b1;
        // Watchdog wins over any busy edge seen in the same cycle.
        if (timer_q == TW'(TIMEOUT)) begin
          enb_d   = 1'b0;
          sad_d   = '1;
          done_d  = gnt_q;
          err_d   = 1'b1;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = cur_q;
          timer_d = '0;
          state_d = IDLE;
        end else if (state_q == START) begin
          if (sad_busy_i) begin
            enb_d   = 1'b0;
            state_d = RUN;
          end
        end else if (!sad_busy_i) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        sad_d   = sad_i;
        done_d  = gnt_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = cur_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      enb_q   <= 1'b0;
      sad_q   <= '0;
      ofs_q   <= '0;
      timer_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      enb_q   <= enb_d;
      sad_q   <= sad_d;
      ofs_q   <= ofs_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign sad_o     = sad_q;
  assign busy_o    = busy_q;
  assign sad_enb_o = enb_q;
  assign sad_ofs_o = ofs_q;

endmodule

// File: tb/tb_sad_sched.sv
// Directed bench for sad_sched with a behavioural SAD engine model
// (busy rises 2 cycles after enable is seen, stays high eng_len cycles).
module tb_sad_sched;

  localparam int N_REQ   = 4;
  localparam int OFS_W   = 8;
  localparam int SAD_W   = 16;
  localparam int TIMEOUT = 1023;

  logic                   clk_i = 1'b0;
  logic                   rstn_i;
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*OFS_W-1:0] ofs_i;
  logic [N_REQ-1:0]       gnt_o, done_o;
  logic                   err_o;
  logic [SAD_W-1:0]       sad_o;
  logic                   busy_o, sad_enb_o;
  logic [OFS_W-1:0]       sad_ofs_o;
  logic                   sad_busy_i;
  logic [SAD_W-1:0]       sad_i;

  logic eng_busy, force_busy, eng_hang;
  int   eng_len;
  int   n_cmp, n_fail;

  assign sad_busy_i = eng_busy | force_busy;

  always #5 clk_i = ~clk_i;

  sad_sched #(
    .N_REQ  (N_REQ),
    .OFS_W  (OFS_W),
    .SAD_W  (SAD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (req_i),
    .ofs_i     (ofs_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .sad_o     (sad_o),
    .busy_o    (busy_o),
    .sad_enb_o (sad_enb_o),
    .sad_ofs_o (sad_ofs_o),
    .sad_busy_i(sad_busy_i),
    .sad_i     (sad_i)
  );

  // Engine model: updates 1ns after each edge, reset by the same rstn_i.
  initial begin : engine
    int ph, cnt;
    eng_busy = 1'b0;
    ph = 0;
    cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rstn_i) begin
        ph = 0; cnt = 0; eng_busy = 1'b0;
      end else begin
        case (ph)
          0: if (sad_enb_o && !eng_hang) begin ph = 1; cnt = 0; end
          1: begin
            cnt++;
            if (cnt == 2) begin eng_busy = 1'b1; ph = 2; cnt = 0; end
          end
          default: begin
            cnt++;
            if (cnt == eng_len) begin eng_busy = 1'b0; ph = 0; end
          end
        endcase
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_gnt(input string nm);
    int k = 0;
    while (gnt_o == '0 && k < 2000) begin tick(); k++; end
    if (gnt_o == '0) expire(nm);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (done_o == '0 && k < 2000) begin tick(); k++; end
    if (done_o == '0) expire(nm);
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int k = 0;
    while (sad_busy_i !== lvl && k < 2000) begin tick(); k++; end
    if (sad_busy_i !== lvl) expire(nm);
  endtask

  task automatic do_reset();
    #3 rstn_i = 1'b0;
    @(posedge clk_i);
    #3 rstn_i = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [N_REQ-1:0] req;
    logic [SAD_W-1:0] sad;
    logic [N_REQ-1:0] gnt;
    logic [OFS_W-1:0] ofs;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [N_REQ-1:0] prev;
    int n;

    // Arbitration sequence starting from last pointer = 0.
    tbl[0] = '{req: 4'b0110, sad: 16'h0101, gnt: 4'b0010, ofs: 8'hB1};
    tbl[1] = '{req: 4'b0101, sad: 16'h0202, gnt: 4'b0100, ofs: 8'hC2};
    tbl[2] = '{req: 4'b1000, sad: 16'h0303, gnt: 4'b1000, ofs: 8'hD3};
    tbl[3] = '{req: 4'b1100, sad: 16'h0404, gnt: 4'b0100, ofs: 8'hC2};
    tbl[4] = '{req: 4'b1001, sad: 16'h0505, gnt: 4'b1000, ofs: 8'hD3};
    tbl[5] = '{req: 4'b0011, sad: 16'h0606, gnt: 4'b0001, ofs: 8'h3C};

    n_cmp = 0; n_fail = 0;
    rstn_i = 1'b0; req_i = '0; ofs_i = 32'hD3C2_B13C; sad_i = 16'h1234;
    force_busy = 1'b0; eng_hang = 1'b0; eng_len = 514;

    #1;
    check("rst_ctl", 32'({gnt_o, done_o, err_o, busy_o, sad_enb_o}), 32'h0);
    check("rst_sad", 32'(sad_o), 32'h0);
    check("rst_ofs", 32'(sad_ofs_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #3 rstn_i = 1'b1;
    tick();

    // Single request with a 514-cycle engine run.
    req_i = 4'b0001;
    tick();
    check("single_gnt", 32'(gnt_o), 32'h1);
    check("single_ofs", 32'(sad_ofs_o), 32'h3C);
    check("single_enb", 32'(sad_enb_o), 32'h1);
    check("single_busy", 32'(busy_o), 32'h1);
    wait_busy(1'b1, "single_busy_rise");
    check("single_enb_held", 32'(sad_enb_o), 32'h1);
    tick();
    check("single_enb_drop", 32'(sad_enb_o), 32'h0);
    wait_busy(1'b0, "single_busy_fall");
    tick();
    check("single_done_early", 32'(done_o), 32'h0);
    tick();
    check("single_done", 32'(done_o), 32'h1);
    check("single_sad", 32'(sad_o), 32'h1234);
    check("single_err", 32'(err_o), 32'h0);
    check("single_ctl_clr", 32'({gnt_o, busy_o}), 32'h0);
    req_i = '0;
    tick();
    check("single_done_pulse", 32'(done_o), 32'h0);
    check("single_sad_hold", 32'(sad_o), 32'h1234);

    // Round-robin from reset with all requesters held.
    do_reset();
    eng_len = 3;
    req_i = 4'b1111;
    prev = '0;
    for (int r = 0; r < 5; r++) begin
      wait_gnt("rr_gnt_wait");
      check("rr_gnt", 32'(gnt_o), 32'(1 << (r % 4)));
      check("rr_no_repeat", 32'(gnt_o == prev), 32'h0);
      prev = gnt_o;
      wait_done("rr_done_wait");
      check("rr_done", 32'(done_o), 32'(prev));
      check("rr_err", 32'(err_o), 32'h0);
      if (r == 4) req_i = '0;
      tick();
      check("rr_done_pulse", 32'(done_o), 32'h0);
    end

    // Table of arbitration vectors.
    for (int i = 0; i < 6; i++) begin
      req_i = tbl[i].req;
      sad_i = tbl[i].sad;
      wait_gnt("tbl_gnt_wait");
      check("tbl_gnt", 32'(gnt_o), 32'(tbl[i].gnt));
      check("tbl_ofs", 32'(sad_ofs_o), 32'(tbl[i].ofs));
      wait_done("tbl_done_wait");
      check("tbl_done", 32'(done_o), 32'(tbl[i].gnt));
      check("tbl_sad", 32'(sad_o), 32'(tbl[i].sad));
      check("tbl_err", 32'(err_o), 32'h0);
      req_i = '0;
      tick();
    end

    // Withdraw before grant, then drop req and change offset mid-RUN.
    eng_len = 40; sad_i = 16'h0BEE;
    force_busy = 1'b1;
    req_i = 4'b1010;
    repeat (3) begin
      tick();
      check("wd_blocked", 32'(gnt_o), 32'h0);
    end
    req_i = 4'b1000;
    tick();
    force_busy = 1'b0;
    tick();
    check("wd_gnt", 32'(gnt_o), 32'h8);
    check("wd_ofs", 32'(sad_ofs_o), 32'hD3);
    wait_busy(1'b1, "wd_busy_rise");
    repeat (3) tick();
    req_i = '0;
    ofs_i[31:24] = 8'h77;
    tick();
    check("wd_ofs_kept", 32'(sad_ofs_o), 32'hD3);
    check("wd_gnt_kept", 32'(gnt_o), 32'h8);
    wait_done("wd_done_wait");
    check("wd_done", 32'(done_o), 32'h8);
    check("wd_sad", 32'(sad_o), 32'h0BEE);
    ofs_i[31:24] = 8'hD3;
    tick();

    // Back-to-back on requester 2.
    eng_len = 3; sad_i = 16'h2222;
    req_i = 4'b0100;
    wait_gnt("b2b_gnt_wait");
    check("b2b_gnt", 32'(gnt_o), 32'h4);
    wait_done("b2b_done_wait");
    check("b2b_done", 32'(done_o), 32'h4);
    tick();
    check("b2b_no_gnt", 32'(gnt_o), 32'h0);
    tick();
    check("b2b_regnt", 32'(gnt_o), 32'h4);
    req_i = '0;
    wait_done("b2b_done2_wait");
    tick();

    // Watchdog: engine never answers.
    eng_hang = 1'b1; sad_i = 16'h5A5A;
    req_i = 4'b0100;
    wait_gnt("to_gnt_wait");
    n = 0;
    while (done_o == '0 && n < 2000) begin tick(); n++; end
    check("to_latency", 32'(n), 32'(TIMEOUT + 1));
    check("to_done", 32'(done_o), 32'h4);
    check("to_err", 32'(err_o), 32'h1);
    check("to_sad", 32'(sad_o), 32'hFFFF);
    check("to_ctl_clr", 32'({gnt_o, busy_o, sad_enb_o}), 32'h0);
    force_busy = 1'b1;
    tick();
    check("to_err_pulse", 32'(err_o), 32'h0);
    repeat (3) begin
      tick();
      check("to_withheld", 32'(gnt_o), 32'h0);
    end
    eng_hang = 1'b0; force_busy = 1'b0; sad_i = 16'h3333;
    tick();
    check("to_regnt", 32'(gnt_o), 32'h4);
    req_i = '0;
    wait_done("to_done2_wait");
    check("to_err2", 32'(err_o), 32'h0);
    check("to_sad2", 32'(sad_o), 32'h3333);
    tick();

    // Asynchronous reset during RUN.
    eng_len = 514; sad_i = 16'h4444;
    req_i = 4'b0100;
    wait_gnt("mr_gnt_wait");
    wait_busy(1'b1, "mr_busy_rise");
    repeat (5) tick();
    #3 rstn_i = 1'b0;
    #1;
    check("mr_ctl", 32'({gnt_o, done_o, err_o, busy_o, sad_enb_o}), 32'h0);
    check("mr_sad", 32'(sad_o), 32'h0);
    check("mr_ofs", 32'(sad_ofs_o), 32'h0);
    req_i = 4'b1001;
    eng_len = 3;
    @(posedge clk_i);
    #3 rstn_i = 1'b1;
    tick();
    check("mr_gnt", 32'(gnt_o), 32'h1);
    check("mr_ofs2", 32'(sad_ofs_o), 32'h3C);
    req_i = '0;
    wait_done("mr_done_wait");
    check("mr_done", 32'(done_o), 32'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
